// File: rtl/fpnew_rounding_arbiter.sv
// fpnew_rounding_arbiter
//   Shares one rounding datapath between NumReq requesters. A round-robin
//   arbiter picks one operand per cycle into S1, which holds the operand and
//   its resolved rounding mode. S1 is rounded into S2, which drives the result
//   outputs. Sticky inexact and illegal-mode flags are kept per requester.
//
// Ports
//   clk_i, rst_i           clock (rising edge), synchronous active-high reset
//   req_valid_i/ready_o    per-requester handshake; ready is one-hot or zero
//   req_abs_i/sign_i       per-requester magnitude and sign
//   req_rs_i               per-requester {round,sticky}
//   req_rm_i               per-requester rounding mode (111 = dynamic)
//   req_effsub_i           per-requester effective-subtraction flag
//   req_tag_i              per-requester opaque tag
//   frm_i                  dynamic rounding mode
//   out_valid_o/ready_i    result handshake
//   out_abs/sign/zero/inexact/id/tag_o   result fields
//   flags_nx_o/ill_o       sticky flags; flags_clr_i clears matching bits
//   busy_o                 an operation is in S1 or S2
module fpnew_rounding_arbiter #(
   parameter int NumReq   = 4,
   parameter int AbsWidth = 32,
   parameter int TagWidth = 4,
   localparam int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NumReq-1:0]            req_valid_i,
   output logic [NumReq-1:0]            req_ready_o,
   input  logic [NumReq*AbsWidth-1:0]   req_abs_i,
   input  logic [NumReq-1:0]            req_sign_i,
   input  logic [NumReq*2-1:0]          req_rs_i,
   input  logic [NumReq*3-1:0]          req_rm_i,
   input  logic [NumReq-1:0]            req_effsub_i,
   input  logic [NumReq*TagWidth-1:0]   req_tag_i,
   input  logic [2:0]                   frm_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [AbsWidth-1:0]          out_abs_o,
   output logic                         out_sign_o,
   output logic                         out_zero_o,
   output logic                         out_inexact_o,
   output logic [IdWidth-1:0]           out_id_o,
   output logic [TagWidth-1:0]          out_tag_o,
   output logic [NumReq-1:0]            flags_nx_o,
   output logic [NumReq-1:0]            flags_ill_o,
   input  logic [NumReq-1:0]            flags_clr_i,
   output logic                         busy_o
);

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;
   localparam logic [2:0] RM_DYN = 3'b111;

   logic [AbsWidth-1:0] abs_arr [NumReq];
   logic [1:0]          rs_arr  [NumReq];
   logic [2:0]          rm_arr  [NumReq];
   logic [TagWidth-1:0] tag_arr [NumReq];

   logic [IdWidth-1:0]  ptr_q, ptr_d;
   logic                s1_valid_q, s1_valid_d;
   logic [AbsWidth-1:0] s1_abs_q;
   logic                s1_sign_q;
   logic [1:0]          s1_rs_q;
   logic [2:0]          s1_mode_q;
   logic                s1_effsub_q;
   logic [IdWidth-1:0]  s1_id_q;
   logic [TagWidth-1:0] s1_tag_q;

   logic                s2_valid_q, s2_valid_d;
   logic [AbsWidth-1:0] s2_abs_q;
   logic                s2_sign_q;
   logic                s2_zero_q;
   logic                s2_inexact_q;
   logic [IdWidth-1:0]  s2_id_q;
   logic [TagWidth-1:0] s2_tag_q;

   logic [NumReq-1:0]   nx_q, nx_d, ill_q, ill_d;
   logic [NumReq-1:0]   nx_set, ill_set;

   logic                win_found;
   logic [IdWidth-1:0]  win_idx;
   logic                s2_ready, s1_adv, accept, s1_to_s2;
   logic [2:0]          sel_rm, mode_raw, mode_res;
   logic                mode_ill;
   logic                round_up, rnd_zero, rnd_sign;
   logic [AbsWidth-1:0] abs_rnd;

   always_comb begin
      for (int i = 0; i < NumReq; i++) begin
         abs_arr[i] = req_abs_i[i*AbsWidth +: AbsWidth];
         rs_arr[i]  = req_rs_i[i*2 +: 2];
         rm_arr[i]  = req_rm_i[i*3 +: 3];
         tag_arr[i] = req_tag_i[i*TagWidth +: TagWidth];
      end
   end

   // Round-robin search: first the requesters at or above the pointer, then
   // the ones below it, which gives the wrap-around order.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (!win_found && (i >= int'(ptr_q)) && req_valid_i[i]) begin
            win_found = 1'b1;
            win_idx   = IdWidth'(i);
         end
      end
      for (int i = 0; i < NumReq; i++) begin
         if (!win_found && (i < int'(ptr_q)) && req_valid_i[i]) begin
            win_found = 1'b1;
            win_idx   = IdWidth'(i);
         end
      end
   end

   // out_ready_i only matters when S2 actually holds a result.
   assign s2_ready = !s2_valid_q || out_ready_i;
   assign s1_adv   = !s1_valid_q || s2_ready;
   assign accept   = win_found && s1_adv;
   assign s1_to_s2 = s1_valid_q && s2_ready;

   assign req_ready_o = accept ? (NumReq'(1) << win_idx) : '0;

   // Mode resolution happens at acceptance so a later frm_i change cannot
   // affect an operation already in flight.
   assign sel_rm   = rm_arr[win_idx];
   assign mode_raw = (sel_rm == RM_DYN) ? frm_i : sel_rm;
   assign mode_ill = (mode_raw > RM_RMM);
   assign mode_res = mode_ill ? RM_RNE : mode_raw;

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (win_idx == IdWidth'(NumReq - 1)) ? '0 : win_idx + IdWidth'(1);
      end
   end

   always_comb begin
      round_up = 1'b0;
      case (s1_mode_q)
         RM_RNE:  round_up = s1_rs_q[1] & (s1_rs_q[0] | s1_abs_q[0]);
         RM_RTZ:  round_up = 1'b0;
         RM_RDN:  round_up = (|s1_rs_q) & s1_sign_q;
         RM_RUP:  round_up = (|s1_rs_q) & ~s1_sign_q;
         RM_RMM:  round_up = s1_rs_q[1];
         default: round_up = 1'b0;
      endcase
   end

   // Carry out of the top bit is dropped on purpose: all-ones rounds to zero.
   assign abs_rnd  = s1_abs_q + AbsWidth'(round_up);
   assign rnd_zero = (s1_abs_q == '0) && (s1_rs_q == 2'b00);
   assign rnd_sign = (rnd_zero && s1_effsub_q) ? (s1_mode_q == RM_RDN) : s1_sign_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (accept) begin
         s1_valid_d = 1'b1;
      end else if (s1_to_s2) begin
         s1_valid_d = 1'b0;
      end
      s2_valid_d = s2_valid_q;
      if (s1_to_s2) begin
         s2_valid_d = 1'b1;
      end else if (out_ready_i) begin
         s2_valid_d = 1'b0;
      end
   end

   // A flag being set in the same cycle as its clear keeps the set.
   assign nx_set  = (s2_valid_q && out_ready_i && s2_inexact_q) ? (NumReq'(1) << s2_id_q) : '0;
   assign ill_set = (accept && mode_ill) ? (NumReq'(1) << win_idx) : '0;
   assign nx_d    = (nx_q & ~flags_clr_i) | nx_set;
   assign ill_d   = (ill_q & ~flags_clr_i) | ill_set;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_abs_q     <= '0;
         s1_sign_q    <= 1'b0;
         s1_rs_q      <= '0;
         s1_mode_q    <= '0;
         s1_effsub_q  <= 1'b0;
         s1_id_q      <= '0;
         s1_tag_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_abs_q     <= '0;
         s2_sign_q    <= 1'b0;
         s2_zero_q    <= 1'b0;
         s2_inexact_q <= 1'b0;
         s2_id_q      <= '0;
         s2_tag_q     <= '0;
         nx_q         <= '0;
         ill_q        <= '0;
      end else begin
         ptr_q      <= ptr_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         nx_q       <= nx_d;
         ill_q      <= ill_d;
         if (accept) begin
            s1_abs_q    <= abs_arr[win_idx];
            s1_sign_q   <= req_sign_i[win_idx];
            s1_rs_q     <= rs_arr[win_idx];
            s1_mode_q   <= mode_res;
            s1_effsub_q <= req_effsub_i[win_idx];
            s1_id_q     <= win_idx;
            s1_tag_q    <= tag_arr[win_idx];
         end
         if (s1_to_s2) begin
            s2_abs_q     <= abs_rnd;
            s2_sign_q    <= rnd_sign;
            s2_zero_q    <= rnd_zero;
            s2_inexact_q <= |s1_rs_q;
            s2_id_q      <= s1_id_q;
            s2_tag_q     <= s1_tag_q;
         end
      end
   end

   assign out_valid_o   = s2_valid_q;
   assign out_abs_o     = s2_abs_q;
   assign out_sign_o    = s2_sign_q;
   assign out_zero_o    = s2_zero_q;
   assign out_inexact_o = s2_inexact_q;
   assign out_id_o      = s2_id_q;
   assign out_tag_o     = s2_tag_q;
   assign flags_nx_o    = nx_q;
   assign flags_ill_o   = ill_q;
   assign busy_o        = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_fpnew_rounding_arbiter.sv
module tb_fpnew_rounding_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int TW = 4;
   localparam int IW = 2;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid, req_ready;
   logic [N*AW-1:0]   req_abs;
   logic [N-1:0]      req_sign;
   logic [N*2-1:0]    req_rs;
   logic [N*3-1:0]    req_rm;
   logic [N-1:0]      req_effsub;
   logic [N*TW-1:0]   req_tag;
   logic [2:0]        frm;
   logic              out_valid, out_ready;
   logic [AW-1:0]     out_abs;
   logic              out_sign, out_zero, out_inexact;
   logic [IW-1:0]     out_id;
   logic [TW-1:0]     out_tag;
   logic [N-1:0]      flags_nx, flags_ill, flags_clr;
   logic              busy;

   logic [AW-1:0] op_abs [N];
   logic          op_sign [N];
   logic [1:0]    op_rs [N];
   logic [2:0]    op_rm [N];
   logic          op_eff [N];
   logic [TW-1:0] op_tag [N];

   int checks = 0;
   int errors = 0;

   fpnew_rounding_arbiter #(.NumReq(N), .AbsWidth(AW), .TagWidth(TW)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_abs_i(req_abs), .req_sign_i(req_sign), .req_rs_i(req_rs),
      .req_rm_i(req_rm), .req_effsub_i(req_effsub), .req_tag_i(req_tag),
      .frm_i(frm),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_abs_o(out_abs), .out_sign_o(out_sign), .out_zero_o(out_zero),
      .out_inexact_o(out_inexact), .out_id_o(out_id), .out_tag_o(out_tag),
      .flags_nx_o(flags_nx), .flags_ill_o(flags_ill), .flags_clr_i(flags_clr),
      .busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_abs    = '0;
      req_sign   = '0;
      req_rs     = '0;
      req_rm     = '0;
      req_effsub = '0;
      req_tag    = '0;
      for (int i = 0; i < N; i++) begin
         req_abs[i*AW +: AW] = op_abs[i];
         req_sign[i]         = op_sign[i];
         req_rs[i*2 +: 2]    = op_rs[i];
         req_rm[i*3 +: 3]    = op_rm[i];
         req_effsub[i]       = op_eff[i];
         req_tag[i*TW +: TW] = op_tag[i];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [AW-1:0] abs;
      logic          sign;
      logic          zero;
      logic          inx;
      logic          ill;
   } res_t;

   typedef struct {
      res_t          r;
      int            id;
      logic [TW-1:0] tag;
      int            acc;
   } item_t;

   typedef struct {
      int            id;
      logic [AW-1:0] abs;
      logic          sign;
      logic [1:0]    rs;
      logic [2:0]    rm;
      logic          eff;
      logic [2:0]    frm;
      logic [TW-1:0] tag;
      logic [N-1:0]  clr;
      logic [AW-1:0] e_abs;
      logic          e_sign;
      logic          e_zero;
      logic          e_inx;
      logic [N-1:0]  e_nx;
      logic [N-1:0]  e_ill;
   } vec_t;

   // Rounding rules written straight from the mode definitions.
   function automatic res_t ref_round(input logic [AW-1:0] a, input logic s, input logic [1:0] rs,
                                      input logic [2:0] rm, input logic eff, input logic [2:0] f);
      res_t r;
      int   m;
      logic up;
      m = (rm == 3'b111) ? int'(f) : int'(rm);
      r.ill = (m > 4);
      if (r.ill) m = 0;
      case (m)
         0:       up = rs[1] && (rs[0] || a[0]);
         1:       up = 1'b0;
         2:       up = (rs != 2'b00) && s;
         3:       up = (rs != 2'b00) && !s;
         default: up = rs[1];
      endcase
      r.abs  = a + AW'(up);
      r.zero = (a == '0) && (rs == 2'b00);
      r.inx  = (rs != 2'b00);
      r.sign = (r.zero && eff) ? (m == 2) : s;
      return r;
   endfunction

   function automatic vec_t mkv(input int id, input logic [AW-1:0] abs, input logic sign,
                                input logic [1:0] rs, input logic [2:0] rm, input logic eff,
                                input logic [2:0] f, input logic [TW-1:0] tag, input logic [N-1:0] clr,
                                input logic [AW-1:0] e_abs, input logic e_sign, input logic e_zero,
                                input logic e_inx, input logic [N-1:0] e_nx, input logic [N-1:0] e_ill);
      vec_t v;
      v.id = id; v.abs = abs; v.sign = sign; v.rs = rs; v.rm = rm; v.eff = eff; v.frm = f;
      v.tag = tag; v.clr = clr; v.e_abs = e_abs; v.e_sign = e_sign; v.e_zero = e_zero;
      v.e_inx = e_inx; v.e_nx = e_nx; v.e_ill = e_ill;
      return v;
   endfunction

   task automatic set_op(input int i, input logic [AW-1:0] a, input logic s, input logic [1:0] rs,
                         input logic [2:0] rm, input logic eff, input logic [TW-1:0] tag);
      op_abs[i] = a; op_sign[i] = s; op_rs[i] = rs; op_rm[i] = rm; op_eff[i] = eff; op_tag[i] = tag;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      flags_clr = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_vec(input int k, input vec_t v);
      @(posedge clk); #1;
      set_op(v.id, v.abs, v.sign, v.rs, v.rm, v.eff, v.tag);
      req_valid = N'(1) << v.id;
      frm = v.frm;
      @(negedge clk);
      chk($sformatf("v%0d ready", k), 64'(req_ready), 64'(N'(1) << v.id));
      @(posedge clk); #1;
      req_valid = '0;
      frm = 3'b000;
      @(negedge clk);
      chk($sformatf("v%0d early_valid", k), 64'(out_valid), 64'(0));
      chk($sformatf("v%0d busy", k), 64'(busy), 64'(1));
      @(negedge clk);
      chk($sformatf("v%0d valid", k), 64'(out_valid), 64'(1));
      chk($sformatf("v%0d abs", k), 64'(out_abs), 64'(v.e_abs));
      chk($sformatf("v%0d sign", k), 64'(out_sign), 64'(v.e_sign));
      chk($sformatf("v%0d zero", k), 64'(out_zero), 64'(v.e_zero));
      chk($sformatf("v%0d inexact", k), 64'(out_inexact), 64'(v.e_inx));
      chk($sformatf("v%0d id", k), 64'(out_id), 64'(v.id));
      chk($sformatf("v%0d tag", k), 64'(out_tag), 64'(v.tag));
      flags_clr = v.clr;
      @(posedge clk); #1;
      flags_clr = '0;
      @(negedge clk);
      chk($sformatf("v%0d nx", k), 64'(flags_nx), 64'(v.e_nx));
      chk($sformatf("v%0d ill", k), 64'(flags_ill), 64'(v.e_ill));
      chk($sformatf("v%0d idle", k), 64'(busy), 64'(0));
   endtask

   vec_t vecs[12];

   initial begin
      logic [N-1:0] acc_mask, exp_ready, set_nx, set_ill, m_nx, m_ill, rdy_cap;
      logic [AW-1:0] snap_abs;
      logic [IW-1:0] snap_id;
      item_t q[$];
      item_t it;
      int ptr, last_leave, cyc, win, acc, got;
      int got_id[3];
      logic [AW-1:0] got_abs[3];
      logic allowed, exp_ov;

      for (int i = 0; i < N; i++) set_op(i, '0, 1'b0, 2'b00, 3'b000, 1'b0, '0);
      frm = 3'b000;
      out_ready = 1'b1;
      do_reset();

      @(negedge clk);
      chk("rst valid", 64'(out_valid), 64'(0));
      chk("rst busy", 64'(busy), 64'(0));
      chk("rst flags", 64'({flags_nx, flags_ill}), 64'(0));
      chk("rst outs", 64'({out_abs, out_sign, out_zero, out_inexact, out_id, out_tag}), 64'(0));
      chk("rst ready", 64'(req_ready), 64'(0));

      //          id abs           s  rs     rm     eff frm     tag clr      e_abs        es ez ei e_nx     e_ill
      vecs[0]  = mkv(0, 32'h10,       0, 2'b10, 3'd0, 0, 3'd0, 3,  4'b0000, 32'h10,       0, 0, 1, 4'b0001, 4'b0000);
      vecs[1]  = mkv(0, 32'h11,       0, 2'b10, 3'd0, 0, 3'd0, 3,  4'b0000, 32'h12,       0, 0, 1, 4'b0001, 4'b0000);
      vecs[2]  = mkv(1, 32'hFFFFFFFF, 0, 2'b01, 3'd7, 0, 3'd3, 5,  4'b0000, 32'h0,        0, 0, 1, 4'b0011, 4'b0000);
      vecs[3]  = mkv(2, 32'h4,        1, 2'b11, 3'd5, 0, 3'd0, 6,  4'b0000, 32'h5,        1, 0, 1, 4'b0111, 4'b0100);
      vecs[4]  = mkv(3, 32'h0,        0, 2'b00, 3'd2, 1, 3'd0, 7,  4'b0000, 32'h0,        1, 1, 0, 4'b0111, 4'b0100);
      vecs[5]  = mkv(3, 32'h0,        0, 2'b00, 3'd0, 1, 3'd0, 8,  4'b0000, 32'h0,        0, 1, 0, 4'b0111, 4'b0100);
      vecs[6]  = mkv(0, 32'h7,        1, 2'b10, 3'd4, 0, 3'd0, 9,  4'b0000, 32'h8,        1, 0, 1, 4'b0111, 4'b0100);
      vecs[7]  = mkv(1, 32'h9,        1, 2'b01, 3'd2, 0, 3'd0, 10, 4'b0000, 32'hA,        1, 0, 1, 4'b0111, 4'b0100);
      vecs[8]  = mkv(2, 32'h9,        0, 2'b11, 3'd1, 0, 3'd0, 11, 4'b0000, 32'h9,        0, 0, 1, 4'b0111, 4'b0100);
      vecs[9]  = mkv(3, 32'h0,        1, 2'b00, 3'd0, 0, 3'd0, 12, 4'b0000, 32'h0,        1, 1, 0, 4'b0111, 4'b0100);
      vecs[10] = mkv(0, 32'h2,        0, 2'b10, 3'd7, 0, 3'd6, 13, 4'b0001, 32'h2,        0, 0, 1, 4'b0111, 4'b0100);
      vecs[11] = mkv(1, 32'h0,        0, 2'b00, 3'd0, 0, 3'd0, 14, 4'b0110, 32'h0,        0, 1, 0, 4'b0001, 4'b0000);

      for (int k = 0; k < 12; k++) run_vec(k, vecs[k]);

      // Round-robin order with every requester permanently valid.
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, AW'(i * 16 + 2), 1'b0, 2'b00, 3'd0, 1'b0, TW'(i));
      req_valid = '1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("rr ready c%0d", k), 64'(req_ready), 64'(N'(1) << (k % N)));
         if (k >= 2) begin
            chk($sformatf("rr valid c%0d", k), 64'(out_valid), 64'(1));
            chk($sformatf("rr id c%0d", k), 64'(out_id), 64'((k - 2) % N));
            chk($sformatf("rr abs c%0d", k), 64'(out_abs), 64'(((k - 2) % N) * 16 + 2));
         end
         @(posedge clk); #1;
      end
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1;

      // Downstream stall with three pending requesters.
      do_reset();
      set_op(0, 32'h100, 1'b0, 2'b10, 3'd0, 1'b0, 4'd1);
      set_op(1, 32'h200, 1'b0, 2'b10, 3'd0, 1'b0, 4'd2);
      set_op(2, 32'h300, 1'b0, 2'b10, 3'd0, 1'b0, 4'd3);
      out_ready = 1'b0;
      req_valid = 4'b0111;
      acc = 0;
      snap_abs = '0;
      snap_id = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         rdy_cap = req_ready;
         if (rdy_cap != '0) acc++;
         chk($sformatf("stall ready c%0d", c), 64'(rdy_cap),
             64'((c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000));
         if (c == 2) begin
            snap_abs = out_abs;
            snap_id = out_id;
            chk("stall valid", 64'(out_valid), 64'(1));
         end else if (c > 2) begin
            chk($sformatf("stall hold c%0d", c), 64'({out_valid, out_id, out_abs}),
                64'({1'b1, snap_id, snap_abs}));
         end
         @(posedge clk); #1;
         req_valid = req_valid & ~rdy_cap;
      end
      chk("stall accepted", 64'(acc), 64'(2));
      out_ready = 1'b1;
      got = 0;
      for (int w = 0; w < 20 && got < 3; w++) begin
         @(negedge clk);
         rdy_cap = req_ready;
         if (out_valid) begin
            got_id[got] = int'(out_id);
            got_abs[got] = out_abs;
            got++;
         end
         @(posedge clk); #1;
         req_valid = req_valid & ~rdy_cap;
      end
      chk("drain count", 64'(got), 64'(3));
      for (int i = 0; i < 3; i++) begin
         if (i < got) begin
            chk($sformatf("drain id %0d", i), 64'(got_id[i]), 64'(i));
            chk($sformatf("drain abs %0d", i), 64'(got_abs[i]), 64'((i + 1) * 256));
         end
      end
      @(negedge clk);
      chk("drain nx", 64'(flags_nx), 64'(4'b0111));

      // Reset while stalled discards everything.
      @(posedge clk); #1;
      out_ready = 1'b0;
      req_valid = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         rdy_cap = req_ready;
         @(posedge clk); #1;
         req_valid = req_valid & ~rdy_cap;
      end
      @(negedge clk);
      chk("pre-rst busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid-rst valid", 64'(out_valid), 64'(0));
      chk("mid-rst busy", 64'(busy), 64'(0));
      chk("mid-rst flags", 64'({flags_nx, flags_ill}), 64'(0));

      // Randomized traffic against a queue-based model.
      ptr = 0;
      last_leave = -10;
      cyc = 0;
      m_nx = '0;
      m_ill = '0;
      acc_mask = '0;
      for (int t = 0; t < 3000; t++) begin
         @(posedge clk); #1;
         req_valid = req_valid & ~acc_mask;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(2) == 0) begin
               case ($urandom_range(3))
                  0:       op_abs[i] = '1;
                  1:       op_abs[i] = '0;
                  default: op_abs[i] = AW'($urandom);
               endcase
               op_sign[i] = 1'($urandom);
               op_rs[i]   = 2'($urandom);
               op_rm[i]   = 3'($urandom);
               op_eff[i]  = 1'($urandom);
               op_tag[i]  = TW'($urandom);
               req_valid[i] = 1'b1;
            end
         end
         out_ready = ($urandom_range(3) != 0);
         frm = 3'($urandom);
         flags_clr = ($urandom_range(15) == 0) ? N'($urandom) : '0;
         @(negedge clk);
         allowed = (q.size() < 2) || out_ready;
         win = -1;
         for (int k = 0; k < N; k++) begin
            if (win < 0 && req_valid[(ptr + k) % N]) win = (ptr + k) % N;
         end
         exp_ready = (allowed && win >= 0) ? (N'(1) << win) : '0;
         chk("rnd ready", 64'(req_ready), 64'(exp_ready));
         exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2) && (cyc >= last_leave + 1);
         chk("rnd valid", 64'(out_valid), 64'(exp_ov));
         chk("rnd busy", 64'(busy), 64'(q.size() > 0));
         if (exp_ov) begin
            chk("rnd result", 64'({out_abs, out_sign, out_zero, out_inexact}),
                64'({q[0].r.abs, q[0].r.sign, q[0].r.zero, q[0].r.inx}));
            chk("rnd id/tag", 64'({out_id, out_tag}), 64'({IW'(q[0].id), q[0].tag}));
         end
         chk("rnd flags", 64'({flags_nx, flags_ill}), 64'({m_nx, m_ill}));
         set_nx = '0;
         set_ill = '0;
         if (exp_ov && out_ready) begin
            if (q[0].r.inx) set_nx[q[0].id] = 1'b1;
            void'(q.pop_front());
            last_leave = cyc;
         end
         acc_mask = exp_ready;
         if (exp_ready != '0) begin
            it.r = ref_round(op_abs[win], op_sign[win], op_rs[win], op_rm[win], op_eff[win], frm);
            it.id = win;
            it.tag = op_tag[win];
            it.acc = cyc;
            q.push_back(it);
            if (it.r.ill) set_ill[win] = 1'b1;
            ptr = (win + 1) % N;
         end
         m_nx = (m_nx & ~flags_clr) | set_nx;
         m_ill = (m_ill & ~flags_clr) | set_ill;
         cyc++;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
